// File: rtl/clkscale_arbiter.sv
// Round-robin owner of the shared clock scaler: programs clkscale for the winner and
// withholds the grant until the divider output has toggled SETTLE times at the new rate.
module clkscale_arbiter #(
   parameter int          NREQ          = 4,
   parameter int          SETTLE        = 2,
   parameter logic [31:0] DEFAULT_SCALE = 32'd50
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   scale_in,
   input  logic                 sclclk,
   output logic [31:0]          clkscale,
   output logic [NREQ-1:0]      grant,
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   // Handshake: req is a level held for the whole ownership; grant is the registered
   // one-hot answer, and dropping req for one edge releases (or abandons) the turn.

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_OWN    = 2'd2
   } state_t;

   state_t          state;
   logic [IW-1:0]   win;
   logic [IW-1:0]   last_owner;
   logic [IW-1:0]   pick;
   logic            any_req;
   logic [31:0]     pick_scale;
   logic [CW-1:0]   settle_cnt;
   logic            sclclk_d;
   logic            toggle;

   assign toggle    = sclclk ^ sclclk_d;
   assign state_dbg = state;

   // Search starts one past the previous owner so every requester gets a turn.
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any_req && req[(int'(last_owner) + k) % NREQ]) begin
            pick    = IW'((int'(last_owner) + k) % NREQ);
            any_req = 1'b1;
         end
      end
   end

   assign pick_scale = scale_in[32*int'(pick) +: 32];

   always_ff @(posedge clk) begin
      sclclk_d <= sclclk;
      if (rst) begin
         state      <= ST_IDLE;
         clkscale   <= DEFAULT_SCALE;
         grant      <= '0;
         busy       <= 1'b0;
         last_owner <= IW'(NREQ - 1);
         settle_cnt <= '0;
         win        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  win      <= pick;
                  clkscale <= pick_scale;
                  busy     <= 1'b1;
                  // An unchanged scale needs no settling: the divider is already there.
                  if (pick_scale == clkscale) begin
                     state <= ST_OWN;
                     grant <= NREQ'(1) << pick;
                  end else begin
                     state      <= ST_SETTLE;
                     settle_cnt <= '0;
                  end
               end
            end
            ST_SETTLE: begin
               if (!req[win]) begin
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                  last_owner <= win;
               end else if (toggle) begin
                  if (settle_cnt == CW'(SETTLE - 1)) begin
                     state      <= ST_OWN;
                     grant      <= NREQ'(1) << win;
                     settle_cnt <= CW'(SETTLE);
                  end else begin
                     settle_cnt <= settle_cnt + 1'b1;
                  end
               end
            end
            ST_OWN: begin
               if (!req[win]) begin
                  grant      <= '0;
                  busy       <= 1'b0;
                  state      <= ST_IDLE;
                  last_owner <= win;
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clkscale_arbiter.sv
// Bench for clkscale_arbiter: a hand-derived vector table, directed multi-cycle corner
// sequences, and randomized traffic compared against an ownership-level reference model.
module tb_clkscale_arbiter;

   localparam int          NREQ = 4;
   localparam int          SETTLE = 2;
   localparam logic [31:0] DEF = 32'd50;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [32*NREQ-1:0]  scale_in;
   logic                sclclk;
   logic [31:0]         clkscale;
   logic [NREQ-1:0]     grant;
   logic                busy;
   logic [1:0]          state_dbg;

   always #5 clk = ~clk;

   clkscale_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE), .DEFAULT_SCALE(DEF)) dut (
      .clk(clk), .rst(rst), .req(req), .scale_in(scale_in), .sclclk(sclclk),
      .clkscale(clkscale), .grant(grant), .busy(busy), .state_dbg(state_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the scaler, who is waiting for it, and how many
   // divider toggles the waiter has seen.
   int          m_owner, m_pend, m_tog, m_last;
   logic [31:0] m_scale;
   logic        m_sprev;

   function automatic logic [31:0] word(input int i);
      return scale_in[32*i +: 32];
   endfunction

   task automatic model_step();
      logic tg;
      int   w;
      tg      = sclclk ^ m_sprev;
      m_sprev = sclclk;
      if (rst) begin
         m_owner = -1; m_pend = -1; m_tog = 0; m_last = NREQ - 1; m_scale = DEF;
         return;
      end
      if (m_owner < 0 && m_pend < 0) begin
         w = -1;
         for (int k = 1; k <= NREQ; k++)
            if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
         if (w >= 0) begin
            if (word(w) == m_scale) m_owner = w;
            else begin m_pend = w; m_tog = 0; end
            m_scale = word(w);
         end
      end else if (m_pend >= 0) begin
         if (!req[m_pend]) begin
            m_last = m_pend; m_pend = -1;
         end else if (tg) begin
            m_tog++;
            if (m_tog == SETTLE) begin m_owner = m_pend; m_pend = -1; end
         end
      end else begin
         if (!req[m_owner]) begin m_last = m_owner; m_owner = -1; end
      end
   endtask

   function automatic logic [NREQ-1:0] exp_grant();
      return (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
   endfunction

   // sclk_mode: 0 = divider following the programmed scale, 1 = random, 2 = held by caller
   int sclk_mode = 2;
   int div_cnt   = 0;

   task automatic tick();
      if (sclk_mode == 0) begin
         if (div_cnt >= int'(m_scale)) begin sclclk = ~sclclk; div_cnt = 0; end
         else div_cnt++;
      end else if (sclk_mode == 1) begin
         sclclk = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      model_step();
      #1;
      chk("model_grant", grant, exp_grant());
      chk("model_busy", busy, (m_owner >= 0 || m_pend >= 0));
      chk("model_clkscale", clkscale, m_scale);
   endtask

   typedef struct {
      logic            rst;
      logic [NREQ-1:0] req;
      logic [31:0]     s0;
      logic            sclk;
      logic [NREQ-1:0] g;
      logic            b;
      logic [31:0]     cs;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic [NREQ-1:0] prev_g, reraise;
      logic [NREQ-1:0] got_q[$];
      logic [NREQ-1:0] exp_q[$];
      int hold;

      rst = 1'b1; req = '0; sclclk = 1'b0;
      scale_in = {32'd3, 32'd3, 32'd3, 32'd3};
      tick(); tick();

      // {rst, req, scale0, sclclk, grant, busy, clkscale}
      tbl[0]  = '{1'b1, 4'b0000, 32'd50, 1'b0, 4'b0000, 1'b0, 32'd50};
      tbl[1]  = '{1'b0, 4'b0001, 32'd50, 1'b0, 4'b0001, 1'b1, 32'd50};
      tbl[2]  = '{1'b0, 4'b0001, 32'd50, 1'b0, 4'b0001, 1'b1, 32'd50};
      tbl[3]  = '{1'b0, 4'b0000, 32'd50, 1'b0, 4'b0000, 1'b0, 32'd50};
      tbl[4]  = '{1'b0, 4'b0010, 32'd3,  1'b0, 4'b0000, 1'b1, 32'd3};
      tbl[5]  = '{1'b0, 4'b0010, 32'd3,  1'b1, 4'b0000, 1'b1, 32'd3};
      tbl[6]  = '{1'b0, 4'b0010, 32'd3,  1'b1, 4'b0000, 1'b1, 32'd3};
      tbl[7]  = '{1'b0, 4'b0010, 32'd3,  1'b0, 4'b0010, 1'b1, 32'd3};
      tbl[8]  = '{1'b0, 4'b0000, 32'd3,  1'b0, 4'b0000, 1'b0, 32'd3};
      tbl[9]  = '{1'b0, 4'b1001, 32'd3,  1'b0, 4'b1000, 1'b1, 32'd3};
      tbl[10] = '{1'b0, 4'b1001, 32'd3,  1'b0, 4'b1000, 1'b1, 32'd3};
      tbl[11] = '{1'b0, 4'b0001, 32'd3,  1'b0, 4'b0000, 1'b0, 32'd3};
      tbl[12] = '{1'b0, 4'b0001, 32'd3,  1'b0, 4'b0001, 1'b1, 32'd3};
      tbl[13] = '{1'b0, 4'b0000, 32'd3,  1'b0, 4'b0000, 1'b0, 32'd3};

      sclk_mode = 2;
      for (int i = 0; i < 14; i++) begin
         rst = tbl[i].rst; req = tbl[i].req; scale_in[31:0] = tbl[i].s0; sclclk = tbl[i].sclk;
         tick();
         chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
         chk($sformatf("tbl%0d_clkscale", i), clkscale, tbl[i].cs);
      end

      // Round robin with every requester asking, each releasing 4 cycles into its turn.
      sclk_mode = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      scale_in = {32'd3, 32'd3, 32'd3, 32'd3};
      req = 4'b1111; prev_g = '0; reraise = '0; hold = 0;
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int cyc = 0; cyc < 400 && got_q.size() < 5; cyc++) begin
         if (grant == '0) begin req |= reraise; reraise = '0; end
         tick();
         if (grant != '0 && grant != prev_g) begin
            chk("rr_idle_gap", prev_g, '0);
            got_q.push_back(grant);
            hold = 0;
         end
         if (grant != '0) begin
            hold++;
            if (hold == 4) begin reraise = grant; req &= ~grant; end
         end
         prev_g = grant;
      end
      chk("rr_count", got_q.size(), 5);
      for (int i = 0; i < 5 && i < got_q.size(); i++) chk($sformatf("rr_order%0d", i), got_q[i], exp_q[i]);
      req = '0; tick(); tick();

      // Requester abandons its turn while the divider is still settling.
      rst = 1'b1; tick(); rst = 1'b0;
      scale_in[95:64] = 32'd100; req = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("abort_nogrant", grant, '0);
      end
      req = 4'b0000; tick();
      chk("abort_busy", busy, 1'b0);
      chk("abort_state", state_dbg, 2'd0);
      chk("abort_clkscale", clkscale, 32'd100);
      scale_in[127:96] = 32'd100; req = 4'b1100; tick();
      chk("abort_next_pick", grant, 4'b1000);
      req = '0; tick();

      // Owner edits its scale word mid-ownership: ignored until it re-requests.
      scale_in[31:0] = 32'd3; req = 4'b0001;
      for (int i = 0; i < 60 && grant != 4'b0001; i++) tick();
      chk("own_grant_timeout", grant, 4'b0001);
      scale_in[31:0] = 32'd7;
      for (int i = 0; i < 5; i++) tick();
      chk("own_scale_held", clkscale, 32'd3);
      chk("own_grant_held", grant, 4'b0001);
      req = '0; tick();

      // Reset in the middle of settling and in the middle of ownership.
      scale_in[63:32] = 32'd9; req = 4'b0010; tick(); tick();
      chk("rst_settle_pre_busy", busy, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_settle_grant", grant, '0);
      chk("rst_settle_busy", busy, 1'b0);
      chk("rst_settle_clkscale", clkscale, DEF);
      scale_in[31:0] = DEF; req = 4'b0001; tick(); tick();
      chk("rst_own_pre_grant", grant, 4'b0001);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_own_grant", grant, '0);
      chk("rst_own_busy", busy, 1'b0);
      chk("rst_own_clkscale", clkscale, DEF);
      scale_in[127:96] = DEF; req = 4'b1001; tick();
      chk("rst_then_pick0", grant, 4'b0001);
      req = '0; tick();

      // Randomized traffic on a random sclclk, checked every cycle by the model.
      sclk_mode = 1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: scale_in[32*$urandom_range(0, NREQ-1) +: 32] = 32'd0;
               1: scale_in[32*$urandom_range(0, NREQ-1) +: 32] = 32'd3;
               2: scale_in[32*$urandom_range(0, NREQ-1) +: 32] = 32'd7;
               default: scale_in[32*$urandom_range(0, NREQ-1) +: 32] = DEF;
            endcase
         end
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
